// File: rtl/regfile_param.sv
// regfile_param: general-purpose register bank.
//   - DATA_W-bit words, 2**ADDR_W entries
//   - two combinational read ports and one synchronous write port
//   - write-to-read bypass
//   - soft-clear engine that zeroes one entry per cycle
// Optional feature macro: REGFILE_ZERO_REG_EN (entry 0 hardwired to zero).
// Reset is synchronous and active-low (rst == 0 at a rising clk edge).

module regfile_param #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam int unsigned Depth = 2 ** ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StDone
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic                busy_q;
  logic                clr_done_q;
  logic [DATA_W-1:0]   mem_q [Depth];

  logic                wr_en;
  logic                waddr_zero;
  logic                bypass_ok;

  // Writes to entry 0 are discarded when it is hardwired to zero.
  assign waddr_zero = ZeroReg && (waddr == '0);

  // Writes and bypass are only honoured while the clear engine is idle.
  assign wr_en     = we && (state_q == StIdle) && !waddr_zero;
  assign bypass_ok = we && !busy_q && !waddr_zero;

  // Clear FSM with registered busy/clr_done; busy mirrors state != StIdle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          clr_done_q <= 1'b0;
          if (clr_req) begin
            state_q <= StClear;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StClear: begin
          // ptr wraps back to 0 as the last entry is swept.
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == ADDR_W'(Depth - 1)) begin
            state_q    <= StDone;
            clr_done_q <= 1'b1;
          end
        end
        StDone: begin
          state_q    <= StIdle;
          busy_q     <= 1'b0;
          clr_done_q <= 1'b0;
        end
        default: begin
          state_q    <= StIdle;
          ptr_q      <= '0;
          busy_q     <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: reset clears all, the sweep clears one entry, else normal write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (state_q == StClear) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_en) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read ports: forced to 0 while busy, then bypass, then array contents.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (!busy_q) begin
      if (bypass_ok && (raddr1 == waddr)) begin
        rdata1 = wdata;
      end else if (!(ZeroReg && (raddr1 == '0))) begin
        rdata1 = mem_q[raddr1];
      end
      if (bypass_ok && (raddr2 == waddr)) begin
        rdata2 = wdata;
      end else if (!(ZeroReg && (raddr2 == '0))) begin
        rdata2 = mem_q[raddr2];
      end
    end
  end

  assign busy     = busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (default DATA_W=32, ADDR_W=5).
// Honours REGFILE_ZERO_REG_EN for the zero-register expectations.

module tb_regfile_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic          clr_req;
  logic          busy;
  logic          clr_done;

  regfile_param #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .rdata1  (rdata1),
    .rdata2  (rdata2),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model: register contents plus a count of remaining busy cycles.
  // A clear ends with every entry zero, and nothing is observable while busy,
  // so the model zeroes the whole array at the moment a clear is accepted.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_cnt = 0;

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
      m_cnt <= 0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end else begin
      if (we && !(ZERO_REG && waddr == 0)) m_mem[waddr] <= wdata;
      if (clr_req) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
        m_cnt <= DEPTH + 1;
      end
    end
  end

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] ra);
    if (m_cnt != 0) return '0;
    if (we && ra == waddr && !(ZERO_REG && waddr == 0)) return wdata;
    if (ZERO_REG && ra == 0) return '0;
    return m_mem[ra];
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_rdata1", rdata1, model_read(raddr1));
      check("cyc_rdata2", rdata2, model_read(raddr2));
      check("cyc_busy", {31'd0, busy}, {31'd0, (m_cnt != 0)});
      check("cyc_clr_done", {31'd0, clr_done}, {31'd0, (m_cnt == 1)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    step();
    we    = 1'b0;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    raddr1 = 5'd7; raddr2 = 5'd31; clr_req = 1'b0;

    // Reset then read
    step();
    chk_en = 1'b1;
    rst    = 1'b1;
    #1;
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_rdata2", rdata2, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_clr_done", {31'd0, clr_done}, 32'd0);

    // Write / readback
    write(5'd5, 32'hDEADBEEF);
    raddr1 = 5'd5; raddr2 = 5'd6;
    #1;
    check("wr_rd5", rdata1, 32'hDEADBEEF);
    check("wr_rd6", rdata2, 32'h0);

    // Bypass on both ports
    write(5'd9, 32'h11111111);
    we = 1'b1; waddr = 5'd9; wdata = 32'h22222222;
    raddr1 = 5'd9; raddr2 = 5'd9;
    #1;
    check("byp_p1", rdata1, 32'h22222222);
    check("byp_p2", rdata2, 32'h22222222);
    step();
    we = 1'b0;
    #1;
    check("byp_commit", rdata1, 32'h22222222);

    // Soft clear with preload
    for (int i = 0; i < DEPTH; i++) write(AW'(i), DW'(i + 1));
    raddr1 = 5'd3; raddr2 = 5'd31;
    #1;
    if (ZERO_REG) begin
      check("pre_rd3", rdata1, 32'd4);
    end else begin
      check("pre_rd3", rdata1, 32'd4);
    end
    check("pre_rd31", rdata2, 32'd32);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 1; c <= DEPTH + 1; c++) begin
      #1;
      check("clr_busy", {31'd0, busy}, 32'd1);
      check("clr_done_pulse", {31'd0, clr_done}, {31'd0, (c == DEPTH + 1)});
      check("clr_rdata", rdata1, 32'h0);
      if (c == 10) begin
        we = 1'b1; waddr = 5'd3; wdata = 32'hAAAA5555;
      end else begin
        we = 1'b0;
      end
      step();
    end
    #1;
    check("clr_end_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      raddr1 = AW'(i);
      #1;
      check("clr_readback", rdata1, 32'h0);
    end

    // Reset mid-clear
    write(5'd12, 32'h12345678);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 1; c < 12; c++) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_clr_done", {31'd0, clr_done}, 32'd0);
    raddr1 = 5'd12;
    #1;
    check("mid_rd12", rdata1, 32'h0);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("reclr_busy", {31'd0, busy}, 32'd1);
    begin
      int  budget;
      bit  seen;
      budget = 0;
      seen   = 1'b0;
      while (busy && budget < 40) begin
        if (clr_done) seen = 1'b1;
        step();
        budget++;
      end
      check("reclr_finished", {31'd0, busy}, 32'd0);
      check("reclr_done_seen", {31'd0, seen}, 32'd1);
    end

    // Entry 0 behaviour
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
    #1;
    check("r0_same_cycle", rdata1, ZERO_REG ? 32'h0 : 32'hFFFFFFFF);
    step();
    we = 1'b0;
    #1;
    check("r0_after", rdata1, ZERO_REG ? 32'h0 : 32'hFFFFFFFF);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
